// File: rtl/accu_pkg.sv
// Shared widths and the sum-to-average helper for the accumulator datapath.
// Build option ACCU_AVG_ROUND_EN selects round-half-up averaging instead of truncation.
package accu_pkg;

   localparam int ACCU_SUM_W = 10;
   localparam int ACCU_AVG_W = 8;
   localparam int ACCU_OVF_W = 8;

   typedef logic [ACCU_SUM_W-1:0] accu_sum_t;
   typedef logic [ACCU_AVG_W-1:0] accu_avg_t;

   localparam logic [ACCU_OVF_W-1:0] ACCU_OVF_MAX = '1;

   // A legal sum never exceeds 1020, so either form of the average fits 8 bits.
   function automatic accu_avg_t sum_to_avg(input accu_sum_t sum);
`ifdef ACCU_AVG_ROUND_EN
      logic [ACCU_SUM_W:0] biased;
      biased = {1'b0, sum} + (ACCU_SUM_W+1)'(2);
      return accu_avg_t'(biased >> 2);
`else
      return accu_avg_t'(sum >> 2);
`endif
   endfunction

endpackage

// File: rtl/accu_avg_fifo_mem.sv
// Register-array storage for the average FIFO: one synchronous write port,
// one combinational read port, every entry cleared by the async reset.
module accu_avg_fifo_mem
   import accu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  accu_avg_t     wdata,
   input  logic [AW-1:0] raddr,
   output accu_avg_t     rdata
);

   accu_avg_t mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/accu_avg_fifo.sv
// Converts accumulator sums to averages and buffers them in a FWFT FIFO with a
// valid/ready output, counting samples dropped while full. Option: ACCU_AVG_ROUND_EN.
module accu_avg_fifo
   import accu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   input  logic [ACCU_SUM_W-1:0]         data_in,
   input  logic                          clear,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [ACCU_AVG_W-1:0]         m_data,
   output logic [$clog2(DEPTH):0]        level,
   output logic                          full,
   output logic                          ovf_flag,
   output logic [ACCU_OVF_W-1:0]         ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          drop;
   accu_avg_t     avg;

   assign avg     = sum_to_avg(data_in);
   assign full    = (level == LVL_FULL);
   assign m_valid = (level != '0);

   // A pop frees a slot in the same cycle, so a full FIFO with m_ready never drops.
   assign pop  = m_valid && m_ready && !clear;
   assign push = valid_in && !clear && (!full || pop);
   assign drop = valid_in && full && !pop && !clear;

   accu_avg_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (avg),
      .raddr (rd_ptr),
      .rdata (m_data)
   );

   // Level is kept apart from the pointers so full and empty never alias.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
         if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_cnt != ACCU_OVF_MAX) begin
               ovf_cnt <= ovf_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_accu_avg_fifo.sv
// Randomised and directed checks of accu_avg_fifo against a queue-based model
// of the FIFO contents and drop counter.
module tb_accu_avg_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_in;
   logic [9:0] data_in;
   logic       clear;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [2:0] level;
   logic       full;
   logic       ovf_flag;
   logic [7:0] ovf_cnt;

   int q[$];
   int mdl_ovf  = 0;
   bit mdl_flag = 1'b0;
   int errors   = 0;
   int checks   = 0;

   accu_avg_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .data_in  (data_in),
      .clear    (clear),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .level    (level),
      .full     (full),
      .ovf_flag (ovf_flag),
      .ovf_cnt  (ovf_cnt)
   );

   always #5 clk = ~clk;

   function automatic int ref_avg(input int s);
`ifdef ACCU_AVG_ROUND_EN
      return (s + 2) / 4;
`else
      return s / 4;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("ovf_flag", 32'(ovf_flag), 32'(mdl_flag));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(mdl_ovf));
      if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
   endtask

   // Called at posedge+1; predicts the effect of the coming edge, then checks it.
   task automatic apply_stimulus(input bit vin, input int din, input bit rdy, input bit clr);
      bit was_full;
      bit do_pop;
      valid_in = vin;
      data_in  = din[9:0];
      m_ready  = rdy;
      clear    = clr;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && rdy && !clr;
      if (clr) begin
         q.delete();
         mdl_ovf  = 0;
         mdl_flag = 1'b0;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (vin) begin
            if (!was_full || do_pop) q.push_back(ref_avg(din));
            else begin
               mdl_flag = 1'b1;
               if (mdl_ovf < 255) mdl_ovf++;
            end
         end
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      clear    = 1'b0;
      check_output();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_m_data"}, 32'(m_data), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_ovf_flag"}, 32'(ovf_flag), 32'd0);
      chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
   endtask

   initial begin
      int sums[$];
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      clear    = 1'b0;
      m_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 0);

      $display("[TB] single max-value pulse");
      apply_stimulus(1, 1020, 1, 0);
      chk("max_valid", 32'(m_valid), 32'd1);
      chk("max_data", 32'(m_data), 32'd255);
      apply_stimulus(0, 0, 1, 0);
      chk("max_drained", 32'(level), 32'd0);

      $display("[TB] averaging of 6 and 5");
      apply_stimulus(1, 6, 0, 0);
`ifdef ACCU_AVG_ROUND_EN
      chk("avg_6", 32'(m_data), 32'd2);
`else
      chk("avg_6", 32'(m_data), 32'd1);
`endif
      apply_stimulus(1, 5, 1, 0);
      chk("avg_5", 32'(m_data), 32'd1);
      apply_stimulus(0, 0, 1, 0);

      $display("[TB] fill and overflow");
      for (int i = 1; i <= 6; i++) apply_stimulus(1, 4 * i, 0, 0);
      chk("fill_level", 32'(level), 32'd4);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ovf_cnt", 32'(ovf_cnt), 32'd2);
      chk("fill_ovf_flag", 32'(ovf_flag), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", 32'(m_data), 32'(i));
         apply_stimulus(0, 0, 1, 0);
      end

      $display("[TB] push and pop while full");
      for (int i = 0; i < 4; i++) apply_stimulus(1, 40 + 8 * i, 0, 0);
      apply_stimulus(1, 400, 1, 0);
      chk("pp_level", 32'(level), 32'd4);
      chk("pp_no_drop", 32'(ovf_cnt), 32'd2);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 0);
      chk("pp_new_last", 32'(m_data), 32'd100);
      apply_stimulus(0, 0, 1, 0);

      $display("[TB] wrap-around rounds");
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) apply_stimulus(1, int'($urandom_range(0, 1020)), 0, 0);
         for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 1, 0);
      end
      for (int i = 0; i < 8; i++) sums.push_back(int'($urandom_range(0, 1020)));
      foreach (sums[i]) apply_stimulus(1, sums[i], $urandom_range(0, 1) == 1, 0);

      $display("[TB] drop-counter saturation");
      for (int i = 0; i < 4 + 300; i++) apply_stimulus(1, int'($urandom_range(0, 1020)), 0, 0);
      chk("sat_cnt", 32'(ovf_cnt), 32'd255);
      chk("sat_flag", 32'(ovf_flag), 32'd1);

      $display("[TB] clear with concurrent sample");
      apply_stimulus(0, 0, 0, 1);
      apply_stimulus(1, 100, 0, 0);
      apply_stimulus(1, 200, 0, 0);
      chk("pre_clear_level", 32'(level), 32'd2);
      apply_stimulus(1, 300, 1, 1);
      chk("clr_level", 32'(level), 32'd0);
      chk("clr_m_valid", 32'(m_valid), 32'd0);
      chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
      apply_stimulus(0, 0, 1, 0);
      chk("clr_not_stored", 32'(level), 32'd0);

      $display("[TB] asynchronous reset mid-operation");
      apply_stimulus(1, 500, 0, 0);
      apply_stimulus(1, 600, 0, 0);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 700, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      q.delete();
      mdl_ovf  = 0;
      mdl_flag = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_stimulus(1, 800, 0, 0);
      apply_stimulus(0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
